// File: rtl/fp16_pkg.sv
// Shared binary16 format constants, the unpacking struct and classification helpers.
package fp16_pkg;

    localparam int FP16_EXP_W   = 5;
    localparam int FP16_FRAC_W  = 10;
    localparam int FP16_BIAS    = 15;
    localparam int FP16_EXP_MAX = 31;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    typedef struct packed {
        logic                   sign;
        logic [FP16_EXP_W-1:0]  exp;
        logic [FP16_FRAC_W-1:0] frac;
    } fp16_t;

    function automatic logic fp16_is_nan(input fp16_t v);
        return (v.exp == FP16_EXP_W'(FP16_EXP_MAX)) && (v.frac != '0);
    endfunction

    function automatic logic fp16_is_inf(input fp16_t v);
        return (v.exp == FP16_EXP_W'(FP16_EXP_MAX)) && (v.frac == '0);
    endfunction

    // Subnormal inputs are flushed, so any zero exponent counts as zero.
    function automatic logic fp16_is_zero(input fp16_t v);
        return v.exp == '0;
    endfunction

endpackage

// File: rtl/fp16_round_norm.sv
// Combinational normalize, round-to-nearest-even and overflow/underflow packing
// of a 22-bit significand product.
module fp16_round_norm
    import fp16_pkg::*;
(
    input  logic [21:0]       prod,
    input  logic signed [7:0] exp_in,
    input  logic              sign,
    output logic [15:0]       result
);

    function automatic logic round_up(input logic lsb, input logic g, input logic r, input logic s);
        return g & (r | s | lsb);
    endfunction

    // Exponent is checked after rounding so a carry into 31 still saturates.
    function automatic logic [15:0] pack_sat(input logic sgn, input logic signed [7:0] e,
                                             input logic [9:0] frac);
        if (e >= 8'sd31)
            return {sgn, 5'h1F, 10'h000};
        else if (e <= 8'sd0)
            return {sgn, 15'h0000};
        else
            return {sgn, e[4:0], frac};
    endfunction

    logic [10:0]       sig;
    logic              guard_b;
    logic              round_b;
    logic              sticky_b;
    logic signed [7:0] e_norm;
    logic [11:0]       sig_rnd;
    logic [9:0]        frac_rnd;
    logic signed [7:0] e_rnd;

    always_comb begin
        if (prod[21]) begin
            sig      = prod[21:11];
            guard_b  = prod[10];
            round_b  = prod[9];
            sticky_b = |prod[8:0];
            e_norm   = exp_in + 8'sd1;
        end else begin
            sig      = prod[20:10];
            guard_b  = prod[9];
            round_b  = prod[8];
            sticky_b = |prod[7:0];
            e_norm   = exp_in;
        end

        sig_rnd = {1'b0, sig} + {11'b0, round_up(sig[0], guard_b, round_b, sticky_b)};

        if (sig_rnd[11]) begin
            frac_rnd = sig_rnd[10:1];
            e_rnd    = e_norm + 8'sd1;
        end else begin
            frac_rnd = sig_rnd[9:0];
            e_rnd    = e_norm;
        end

        result = pack_sat(sign, e_rnd, frac_rnd);
    end

endmodule

// File: rtl/fp16_multiply.sv
// Binary16 multiplier: unpack, special-case selection, 11x11 significand multiply
// and a single registered output stage with a ready pulse.
module fp16_multiply
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_A,
    input  logic [15:0] in_B,
    input  logic        in_En,
    output logic [15:0] out_Out,
    output logic        out_Ready,
    output logic [10:0] fractionWire
);

    localparam logic signed [7:0] BIAS_S = 8'(FP16_BIAS);

    fp16_t             a_p0;
    fp16_t             b_p0;
    logic              sign_p0;
    logic [21:0]       prod_p0;
    logic signed [7:0] exp_p0;
    logic [15:0]       norm_p0;
    logic [15:0]       result_p0;
    logic [10:0]       frac_dbg_p0;

    logic [15:0]       result_p1;
    logic [10:0]       frac_dbg_p1;
    logic              vld_p1;

    assign a_p0    = in_A;
    assign b_p0    = in_B;
    assign sign_p0 = a_p0.sign ^ b_p0.sign;
    assign prod_p0 = {11'b0, 1'b1, a_p0.frac} * {11'b0, 1'b1, b_p0.frac};
    assign exp_p0  = $signed({3'b000, a_p0.exp}) + $signed({3'b000, b_p0.exp}) - BIAS_S;

    fp16_round_norm u_round_norm (
        .prod   (prod_p0),
        .exp_in (exp_p0),
        .sign   (sign_p0),
        .result (norm_p0)
    );

    always_comb begin
        result_p0 = norm_p0;
        if (fp16_is_nan(a_p0) || fp16_is_nan(b_p0))
            result_p0 = FP16_QNAN;
        else if ((fp16_is_inf(a_p0) && fp16_is_zero(b_p0)) ||
                 (fp16_is_inf(b_p0) && fp16_is_zero(a_p0)))
            result_p0 = FP16_QNAN;
        else if (fp16_is_inf(a_p0) || fp16_is_inf(b_p0))
            result_p0 = {sign_p0, 5'h1F, 10'h000};
        else if (fp16_is_zero(a_p0) || fp16_is_zero(b_p0))
            result_p0 = {sign_p0, 15'h0000};
    end

    // Debug significand is only meaningful for normal results.
    always_comb begin
        frac_dbg_p0 = {1'b1, result_p0[9:0]};
        if (result_p0[14:10] == 5'h00 || result_p0[14:10] == 5'h1F)
            frac_dbg_p0 = 11'h000;
    end

    // Stage p0 -> p1: output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_p1   <= '0;
            frac_dbg_p1 <= '0;
            vld_p1      <= 1'b0;
        end else begin
            vld_p1 <= in_En;
            if (in_En) begin
                result_p1   <= result_p0;
                frac_dbg_p1 <= frac_dbg_p0;
            end
        end
    end

    assign out_Out      = result_p1;
    assign out_Ready    = vld_p1;
    assign fractionWire = frac_dbg_p1;

endmodule

// File: tb/tb_fp16_multiply.sv
// Self-checking bench for fp16_multiply: real-arithmetic reference model with a
// per-cycle compare process, plus directed vectors with literal expectations.
module tb_fp16_multiply;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_A = '0;
    logic [15:0] in_B = '0;
    logic        in_En = 1'b0;
    logic [15:0] out_Out;
    logic        out_Ready;
    logic [10:0] fractionWire;

    int checks = 0;
    int failures = 0;

    fp16_multiply dut (
        .clk          (clk),
        .rst          (rst),
        .in_A         (in_A),
        .in_B         (in_B),
        .in_En        (in_En),
        .out_Out      (out_Out),
        .out_Ready    (out_Ready),
        .fractionWire (fractionWire)
    );

    always #5 clk = ~clk;

    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    // Reference: decode to reals, multiply exactly, re-encode with ties-to-even.
    function automatic logic [15:0] model_mul(input logic [15:0] a, input logic [15:0] b);
        logic s;
        int   ea, eb, fa, fb, e, mi, be;
        logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        real  v, m, rem;
        logic [15:0] res;
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        fa = int'(a[9:0]);   fb = int'(b[9:0]);
        nan_a = (ea == 31) && (fa != 0);  nan_b = (eb == 31) && (fb != 0);
        inf_a = (ea == 31) && (fa == 0);  inf_b = (eb == 31) && (fb == 0);
        zero_a = (ea == 0);               zero_b = (eb == 0);
        if (nan_a || nan_b) return 16'h7E00;
        if ((inf_a && zero_b) || (inf_b && zero_a)) return 16'h7E00;
        if (inf_a || inf_b) return {s, 15'h7C00};
        if (zero_a || zero_b) return {s, 15'h0000};
        v = real'(1024 + fa) * pow2(ea - 25) * real'(1024 + fb) * pow2(eb - 25);
        e = 0;
        while (v >= pow2(e + 1)) e++;
        while (v < pow2(e)) e--;
        m   = v * pow2(10 - e);
        mi  = $rtoi(m);
        rem = m - real'(mi);
        if (rem > 0.5 || (rem == 0.5 && (mi % 2) == 1)) mi++;
        if (mi == 2048) begin mi = 1024; e++; end
        be = e + 15;
        if (be >= 31) return {s, 15'h7C00};
        if (be <= 0)  return {s, 15'h0000};
        res = {s, 5'(be), 10'(mi)};
        return res;
    endfunction

    function automatic logic [10:0] model_frac(input logic [15:0] r);
        if (r[14:10] == 5'd0 || r[14:10] == 5'd31) return 11'h000;
        return {1'b1, r[9:0]};
    endfunction

    logic [15:0] m_out  = '0;
    logic        m_rdy  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out <= '0;
            m_rdy <= 1'b0;
        end else begin
            m_rdy <= in_En;
            if (in_En) m_out <= model_mul(in_A, in_B);
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_out", out_Out, m_out);
        chk("cmp_rdy", {15'b0, out_Ready}, {15'b0, m_rdy});
        chk("cmp_frac", {5'b0, fractionWire}, {5'b0, model_frac(m_out)});
    end

    task automatic single_op(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] req);
        @(negedge clk);
        in_A = a; in_B = b; in_En = 1'b1;
        @(negedge clk);
        in_En = 1'b0;
        chk({name, "_out"}, out_Out, req);
        chk({name, "_rdy"}, {15'b0, out_Ready}, 16'd1);
        @(negedge clk);
        chk({name, "_rdy_low"}, {15'b0, out_Ready}, 16'd0);
        chk({name, "_hold"}, out_Out, req);
    endtask

    initial begin
        #1;
        chk("reset_out", out_Out, 16'h0000);
        chk("reset_rdy", {15'b0, out_Ready}, 16'd0);
        chk("reset_frac", {5'b0, fractionWire}, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        single_op("mul_123", 16'h57B7, 16'hD7B7, 16'hF371);
        chk("mul_123_frac", {5'b0, fractionWire}, 16'h0771);
        single_op("one_two", 16'h3C00, 16'h4000, 16'h4000);
        single_op("m3_m3", 16'hC200, 16'hC200, 16'h4880);
        single_op("overflow", 16'h7BFF, 16'h4000, 16'h7C00);
        chk("overflow_frac", {5'b0, fractionWire}, 16'h0000);
        single_op("inf_zero", 16'h7C00, 16'h0000, 16'h7E00);
        single_op("negzero", 16'h8000, 16'h3C00, 16'h8000);
        single_op("underflow", 16'h0400, 16'h0400, 16'h0000);
        single_op("nan_in", 16'h7E00, 16'h3C00, 16'h7E00);
        single_op("inf_neg", 16'h7C00, 16'hC000, 16'hFC00);

        // Reset lands between the enable edge and the following edge.
        @(negedge clk);
        in_A = 16'h3C00; in_B = 16'h4000; in_En = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_out", out_Out, 16'h0000);
        chk("rst_mid_rdy", {15'b0, out_Ready}, 16'd0);
        @(negedge clk);
        in_En = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_pulse", {15'b0, out_Ready}, 16'd0);

        // Three back-to-back operations.
        @(negedge clk);
        in_A = 16'h3C00; in_B = 16'h4000; in_En = 1'b1;
        @(negedge clk);
        chk("b2b_0", out_Out, 16'h4000);
        chk("b2b_0_rdy", {15'b0, out_Ready}, 16'd1);
        in_A = 16'hC200; in_B = 16'hC200;
        @(negedge clk);
        chk("b2b_1", out_Out, 16'h4880);
        chk("b2b_1_rdy", {15'b0, out_Ready}, 16'd1);
        in_A = 16'h4200; in_B = 16'h4000;
        @(negedge clk);
        chk("b2b_2", out_Out, 16'h4600);
        chk("b2b_2_rdy", {15'b0, out_Ready}, 16'd1);
        in_En = 1'b0;
        @(negedge clk);
        chk("b2b_end_rdy", {15'b0, out_Ready}, 16'd0);

        // Broad sweep checked by the model through the compare process.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            in_A  = 16'($urandom);
            in_B  = 16'($urandom);
            in_En = 1'($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        in_En = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
